// File: rtl/sequencia_controle_param.sv
// Control unit for the sequence-comparison datapath.
// One position per ESPERA/REGISTRA/COMPARACAO pass; a result is held until the next round starts.
// No backpressure: jogada is taken in ESPERA only, igual in COMPARACAO only, iniciar in INICIAL/FIM_* only.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   iniciar, jogada, igual start request, player entry valid, comparator result
//   zeraR, registraR       entry register clear / load strobes
//   endereco, erros        current memory address, mismatch count of the round
//   pronto, acertou,       round finished / no mismatch / >=1 mismatch / ended by timeout
//   errou, timeout
//   db_estado              debug state code
module sequencia_controle_param #(
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT     = 5000,
  parameter int STOP_ON_ERR = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  output logic              zeraR,
  output logic              registraR,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W:0]   erros,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [3:0]        db_estado
);

  // Timer must hold TIMEOUT-1; keep at least one bit so the disabled case still elaborates.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TIMER_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ERR_MAX    = (ADDR_W + 1)'(DEPTH);

  // State encoding doubles as the debug code.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  estado_t           estado;
  estado_t           estado_nxt;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_nxt;
  logic [ADDR_W-1:0] endereco_nxt;
  logic [ADDR_W:0]   erros_nxt;

  // Next-state and datapath-register update.
  always_comb begin
    estado_nxt   = INICIAL;
    endereco_nxt = endereco;
    erros_nxt    = erros;
    timer_nxt    = timer;
    case (estado)
      INICIAL: begin
        estado_nxt = iniciar ? PREPARACAO : INICIAL;
      end
      PREPARACAO: begin
        endereco_nxt = '0;
        erros_nxt    = '0;
        timer_nxt    = '0;
        estado_nxt   = ESPERA;
      end
      ESPERA: begin
        // An entry arriving on the last allowed cycle still counts.
        if (jogada) begin
          estado_nxt = REGISTRA;
        end else if (TIMEOUT != 0 && timer == TIMER_LAST) begin
          estado_nxt = FIM_TIMEOUT;
        end else begin
          estado_nxt = ESPERA;
          if (TIMEOUT != 0) begin
            timer_nxt = timer + 1'b1;
          end
        end
      end
      REGISTRA: begin
        estado_nxt = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual && erros < ERR_MAX) begin
          erros_nxt = erros + 1'b1;
        end
        // The end-of-round verdict uses the count including this compare.
        if (!igual && STOP_ON_ERR != 0) begin
          estado_nxt = FIM_ERRO;
        end else if (endereco == ADDR_LAST) begin
          estado_nxt = (erros_nxt == '0) ? FIM_ACERTO : FIM_ERRO;
        end else begin
          estado_nxt = PROXIMO;
        end
      end
      PROXIMO: begin
        // Only reached below the last address, so endereco cannot wrap.
        endereco_nxt = endereco + 1'b1;
        timer_nxt    = '0;
        estado_nxt   = ESPERA;
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        estado_nxt = iniciar ? PREPARACAO : estado;
      end
      default: begin
        estado_nxt = INICIAL;
      end
    endcase
  end

  // State, counters and registered Moore outputs (decoded from the next state).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      endereco  <= '0;
      erros     <= '0;
      timer     <= '0;
      zeraR     <= 1'b1;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      estado    <= estado_nxt;
      endereco  <= endereco_nxt;
      erros     <= erros_nxt;
      timer     <= timer_nxt;
      zeraR     <= (estado_nxt == INICIAL) || (estado_nxt == PREPARACAO);
      registraR <= (estado_nxt == REGISTRA);
      pronto    <= (estado_nxt == FIM_ACERTO) || (estado_nxt == FIM_ERRO) ||
                   (estado_nxt == FIM_TIMEOUT);
      acertou   <= (estado_nxt == FIM_ACERTO);
      errou     <= (estado_nxt == FIM_ERRO);
      timeout   <= (estado_nxt == FIM_TIMEOUT);
    end
  end

  // Debug code; any encoding outside the legal set shows as F.
  always_comb begin
    db_estado = 4'hF;
    case (estado)
      INICIAL, PREPARACAO, ESPERA, REGISTRA, COMPARACAO, PROXIMO,
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: db_estado = estado;
      default:                           db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_sequencia_controle_param.sv
module tb_sequencia_controle_param;

  logic       clock = 1'b0;
  logic       reset;
  int         checks   = 0;
  int         failures = 0;

  // Instance A: stop on first error.  Instance B: full pass, errors counted.
  logic       a_iniciar, a_jogada, a_igual;
  logic       a_zeraR, a_registraR, a_pronto, a_acertou, a_errou, a_timeout;
  logic [3:0] a_endereco;
  logic [4:0] a_erros;
  logic [3:0] a_db;

  logic       b_iniciar, b_jogada, b_igual;
  logic       b_zeraR, b_registraR, b_pronto, b_acertou, b_errou, b_timeout;
  logic [3:0] b_endereco;
  logic [4:0] b_erros;
  logic [3:0] b_db;

  always #5 clock = ~clock;

  sequencia_controle_param #(.ADDR_W(4), .DEPTH(4), .TIMEOUT(10), .STOP_ON_ERR(1)) dut_a (
    .clock(clock), .reset(reset), .iniciar(a_iniciar), .jogada(a_jogada), .igual(a_igual),
    .zeraR(a_zeraR), .registraR(a_registraR), .endereco(a_endereco), .erros(a_erros),
    .pronto(a_pronto), .acertou(a_acertou), .errou(a_errou), .timeout(a_timeout),
    .db_estado(a_db)
  );

  sequencia_controle_param #(.ADDR_W(4), .DEPTH(4), .TIMEOUT(10), .STOP_ON_ERR(0)) dut_b (
    .clock(clock), .reset(reset), .iniciar(b_iniciar), .jogada(b_jogada), .igual(b_igual),
    .zeraR(b_zeraR), .registraR(b_registraR), .endereco(b_endereco), .erros(b_erros),
    .pronto(b_pronto), .acertou(b_acertou), .errou(b_errou), .timeout(b_timeout),
    .db_estado(b_db)
  );

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one entry on A from ESPERA; returns after the compare edge.
  task automatic a_pos(input logic ig);
    a_jogada = 1'b1; a_igual = ig;
    tick();
    a_jogada = 1'b0;
    tick();
    tick();
  endtask

  task automatic b_pos(input logic ig);
    b_jogada = 1'b1; b_igual = ig;
    tick();
    b_jogada = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_iniciar = 0; a_jogada = 0; a_igual = 0;
    b_iniciar = 0; b_jogada = 0; b_igual = 0;
    #12;
    checks++; if (a_db !== 4'h0) begin failures++; $display("FAIL reset_db got=%0h exp=0", a_db); end
    checks++; if (a_zeraR !== 1'b1) begin failures++; $display("FAIL reset_zeraR got=%0b exp=1", a_zeraR); end
    checks++; if ({a_registraR, a_pronto, a_acertou, a_errou, a_timeout} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%05b exp=00000", {a_registraR, a_pronto, a_acertou, a_errou, a_timeout}); end
    checks++; if (a_endereco !== 4'd0 || a_erros !== 5'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", a_endereco, a_erros); end
    @(posedge clock); #1 reset = 1'b1;
    tick(); tick();
    checks++; if (a_db !== 4'h0 || b_db !== 4'h0) begin
      failures++; $display("FAIL idle_hold got=%0h/%0h exp=0/0", a_db, b_db); end
  endtask

  task automatic test_acerto();
    a_iniciar = 1'b1;
    tick();
    checks++; if (a_db !== 4'h1 || a_zeraR !== 1'b1) begin
      failures++; $display("FAIL acerto_prep got=%0h/%0b exp=1/1", a_db, a_zeraR); end
    a_iniciar = 1'b0;
    tick();
    checks++; if (a_db !== 4'h2 || a_zeraR !== 1'b0) begin
      failures++; $display("FAIL acerto_espera got=%0h/%0b exp=2/0", a_db, a_zeraR); end
    for (int p = 0; p < 4; p++) begin
      a_jogada = 1'b1; a_igual = 1'b1;
      tick();
      checks++; if (a_db !== 4'h4 || a_registraR !== 1'b1) begin
        failures++; $display("FAIL acerto_registra pos=%0d got=%0h/%0b exp=4/1", p, a_db, a_registraR); end
      a_jogada = 1'b0;
      tick();
      tick();
      if (p < 3) begin
        checks++; if (a_db !== 4'h6) begin failures++; $display("FAIL acerto_proximo pos=%0d got=%0h exp=6", p, a_db); end
        tick();
        checks++; if (a_endereco !== 4'(p + 1)) begin
          failures++; $display("FAIL acerto_addr got=%0d exp=%0d", a_endereco, p + 1); end
      end
    end
    checks++; if (a_db !== 4'hA || a_pronto !== 1'b1 || a_acertou !== 1'b1 || a_errou !== 1'b0) begin
      failures++; $display("FAIL acerto_end got=%0h p%0b a%0b e%0b exp=A p1 a1 e0", a_db, a_pronto, a_acertou, a_errou); end
    checks++; if (a_endereco !== 4'd3 || a_erros !== 5'd0) begin
      failures++; $display("FAIL acerto_counts got=%0d/%0d exp=3/0", a_endereco, a_erros); end
    a_jogada = 1'b1;  // entries outside ESPERA must be ignored
    for (int i = 0; i < 20; i++) tick();
    a_jogada = 1'b0;
    checks++; if (a_db !== 4'hA || a_pronto !== 1'b1 || a_endereco !== 4'd3) begin
      failures++; $display("FAIL acerto_hold got=%0h/%0b/%0d exp=A/1/3", a_db, a_pronto, a_endereco); end
  endtask

  task automatic test_stop_err();
    a_iniciar = 1'b1; tick(); a_iniciar = 1'b0; tick();
    checks++; if (a_db !== 4'h2 || a_endereco !== 4'd0) begin
      failures++; $display("FAIL stop_restart got=%0h/%0d exp=2/0", a_db, a_endereco); end
    a_pos(1'b1); tick();
    a_pos(1'b1); tick();
    a_pos(1'b0);
    checks++; if (a_db !== 4'hE || a_errou !== 1'b1 || a_acertou !== 1'b0 || a_pronto !== 1'b1) begin
      failures++; $display("FAIL stop_end got=%0h e%0b a%0b p%0b exp=E e1 a0 p1", a_db, a_errou, a_acertou, a_pronto); end
    checks++; if (a_endereco !== 4'd2 || a_erros !== 5'd1) begin
      failures++; $display("FAIL stop_counts got=%0d/%0d exp=2/1", a_endereco, a_erros); end
  endtask

  task automatic test_full_pass();
    b_iniciar = 1'b1; tick(); b_iniciar = 1'b0; tick();
    b_pos(1'b1);
    checks++; if (b_db !== 4'h6 || b_erros !== 5'd0) begin
      failures++; $display("FAIL full_p0 got=%0h/%0d exp=6/0", b_db, b_erros); end
    tick();
    b_pos(1'b0);
    checks++; if (b_db !== 4'h6 || b_erros !== 5'd1) begin
      failures++; $display("FAIL full_p1 got=%0h/%0d exp=6/1", b_db, b_erros); end
    tick();
    b_pos(1'b1); tick();
    b_pos(1'b0);
    checks++; if (b_db !== 4'hE || b_errou !== 1'b1 || b_acertou !== 1'b0) begin
      failures++; $display("FAIL full_end got=%0h e%0b a%0b exp=E e1 a0", b_db, b_errou, b_acertou); end
    checks++; if (b_erros !== 5'd2 || b_endereco !== 4'd3) begin
      failures++; $display("FAIL full_counts got=%0d/%0d exp=2/3", b_erros, b_endereco); end
  endtask

  task automatic test_timeout();
    a_iniciar = 1'b1; tick(); a_iniciar = 1'b0; tick();
    // Cycle 1 of ESPERA is visible now; nine more edges reach cycle 10.
    for (int i = 2; i <= 10; i++) begin
      tick();
      checks++; if (a_db !== 4'h2) begin failures++; $display("FAIL to_wait cycle=%0d got=%0h exp=2", i, a_db); end
    end
    tick();
    checks++; if (a_db !== 4'hD || a_timeout !== 1'b1 || a_pronto !== 1'b1 || a_errou !== 1'b0) begin
      failures++; $display("FAIL to_end got=%0h t%0b p%0b e%0b exp=D t1 p1 e0", a_db, a_timeout, a_pronto, a_errou); end
    a_iniciar = 1'b1; tick(); a_iniciar = 1'b0; tick();
    for (int i = 2; i <= 10; i++) tick();
    a_jogada = 1'b1; a_igual = 1'b1;
    tick();
    a_jogada = 1'b0;
    checks++; if (a_db !== 4'h4 || a_timeout !== 1'b0) begin
      failures++; $display("FAIL to_late_entry got=%0h/%0b exp=4/0", a_db, a_timeout); end
  endtask

  task automatic test_restart();
    b_iniciar = 1'b1; tick();
    checks++; if (b_db !== 4'h1) begin failures++; $display("FAIL restart_prep got=%0h exp=1", b_db); end
    b_iniciar = 1'b0; tick();
    checks++; if (b_db !== 4'h2 || b_endereco !== 4'd0 || b_erros !== 5'd0) begin
      failures++; $display("FAIL restart_espera got=%0h/%0d/%0d exp=2/0/0", b_db, b_endereco, b_erros); end
  endtask

  task automatic test_reset_mid();
    b_pos(1'b0); tick();
    checks++; if (b_db !== 4'h2 || b_endereco !== 4'd1 || b_erros !== 5'd1) begin
      failures++; $display("FAIL mid_setup got=%0h/%0d/%0d exp=2/1/1", b_db, b_endereco, b_erros); end
    b_jogada = 1'b1; b_igual = 1'b1;
    tick();
    b_jogada = 1'b0; b_iniciar = 1'b1;  // start request during REGISTRA
    tick();
    b_iniciar = 1'b0;
    checks++; if (b_db !== 4'h5) begin failures++; $display("FAIL mid_iniciar_ignored got=%0h exp=5", b_db); end
    #2 reset = 1'b0;
    #1;
    checks++; if (b_db !== 4'h0 || b_endereco !== 4'd0 || b_erros !== 5'd0 || b_pronto !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%0h/%0d/%0d/%0b exp=0/0/0/0", b_db, b_endereco, b_erros, b_pronto); end
    checks++; if (b_zeraR !== 1'b1 || a_db !== 4'h0) begin
      failures++; $display("FAIL mid_reset_misc got=%0b/%0h exp=1/0", b_zeraR, a_db); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (b_db !== 4'h0) begin failures++; $display("FAIL mid_after got=%0h exp=0", b_db); end
  endtask

  initial begin
    test_reset();
    test_acerto();
    test_stop_err();
    test_full_pass();
    test_timeout();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
